// File: rtl/slave_interface.sv
// Receiving end of the valid/ready word link: buffers accepted words in a
// first-word-fall-through FIFO and hands them to a consumer that stalls with busy.
module slave_interface #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned LVL_W  = $clog2(DEPTH + 1),
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] i_slave_data,
   input  logic              i_slave_valid,
   output logic              o_slave_ready,
   output logic [DATA_W-1:0] o_slave_out_data,
   output logic              o_slave_out_valid,
   input  logic              i_slave_busy,
   output logic [LVL_W-1:0]  o_slave_level,
   output logic [CNT_W-1:0]  o_slave_words
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [LVL_W-1:0]  count_q;
   logic [CNT_W-1:0]  words_q;
   logic              push;
   logic              pop;

   // Flags come only from registered occupancy, so no valid/busy to ready/valid path.
   assign o_slave_ready     = (count_q != LVL_W'(DEPTH));
   assign o_slave_out_valid = (count_q != '0);
   assign o_slave_out_data  = mem_q[rd_ptr_q];
   assign o_slave_level     = count_q;
   assign o_slave_words     = words_q;

   assign push = i_slave_valid & o_slave_ready;
   assign pop  = o_slave_out_valid & ~i_slave_busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         words_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            words_q  <= words_q + CNT_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         if (push && !pop) begin
            count_q <= count_q + LVL_W'(1);
         end else if (pop && !push) begin
            count_q <= count_q - LVL_W'(1);
         end
      end
   end

   // Storage is not reset; only the pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= i_slave_data;
      end
   end

endmodule

// File: tb/tb_slave_interface.sv
// Self-checking bench for slave_interface: scoreboard queue fed on every accepted
// word and drained on every consumed word, plus per-scenario directed checks.
module tb_slave_interface;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned LVL_W  = $clog2(DEPTH + 1);
   localparam int unsigned CNT_W  = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [DATA_W-1:0] i_slave_data;
   logic              i_slave_valid;
   logic              o_slave_ready;
   logic [DATA_W-1:0] o_slave_out_data;
   logic              o_slave_out_valid;
   logic              i_slave_busy;
   logic [LVL_W-1:0]  o_slave_level;
   logic [CNT_W-1:0]  o_slave_words;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [DATA_W-1:0] sb_q [$];
   int                exp_words = 0;

   slave_interface #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .LVL_W (LVL_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .i_slave_data     (i_slave_data),
      .i_slave_valid    (i_slave_valid),
      .o_slave_ready    (o_slave_ready),
      .o_slave_out_data (o_slave_out_data),
      .o_slave_out_valid(o_slave_out_valid),
      .i_slave_busy     (i_slave_busy),
      .o_slave_level    (o_slave_level),
      .o_slave_words    (o_slave_words)
   );

   always #5 clk = ~clk;

   // Scoreboard monitor: inputs are stable at the falling edge, so the handshakes
   // seen here are exactly the ones the next rising edge will act on.
   always @(negedge clk) begin
      logic [DATA_W-1:0] exp_data;
      if (rst) begin
         sb_q.delete();
         exp_words = 0;
      end else begin
         tests_run++;
         if (32'(o_slave_level) !== sb_q.size()) begin
            tests_failed++;
            $display("FAIL mon_level: got %0d expected %0d", o_slave_level, sb_q.size());
         end
         tests_run++;
         if (o_slave_ready !== (sb_q.size() != DEPTH)) begin
            tests_failed++;
            $display("FAIL mon_ready: got %b expected %b", o_slave_ready, sb_q.size() != DEPTH);
         end
         tests_run++;
         if (o_slave_out_valid !== (sb_q.size() != 0)) begin
            tests_failed++;
            $display("FAIL mon_out_valid: got %b expected %b", o_slave_out_valid,
                     sb_q.size() != 0);
         end
         tests_run++;
         if (32'(o_slave_words) !== (exp_words % (1 << CNT_W))) begin
            tests_failed++;
            $display("FAIL mon_words: got %0d expected %0d", o_slave_words, exp_words);
         end
         if (o_slave_out_valid === 1'b1 && i_slave_busy === 1'b0) begin
            tests_run++;
            if (sb_q.size() == 0) begin
               tests_failed++;
               $display("FAIL mon_pop_empty: got word %h expected none", o_slave_out_data);
            end else begin
               exp_data = sb_q.pop_front();
               if (o_slave_out_data !== exp_data) begin
                  tests_failed++;
                  $display("FAIL mon_out_data: got %h expected %h", o_slave_out_data, exp_data);
               end
            end
         end
         if (i_slave_valid === 1'b1 && o_slave_ready === 1'b1) begin
            sb_q.push_back(i_slave_data);
            exp_words++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int guard = 0;
      i_slave_valid = 1'b0;
      i_slave_busy  = 1'b0;
      while (o_slave_out_valid === 1'b1 && guard < 20) begin
         tick();
         guard++;
      end
      tests_run++;
      if (o_slave_out_valid !== 1'b0 || sb_q.size() != 0) begin
         tests_failed++;
         $display("FAIL drain: got out_valid=%b pending=%0d expected 0/0",
                  o_slave_out_valid, sb_q.size());
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst           = 1'b1;
      i_slave_valid = 1'b1;
      i_slave_data  = 32'h0BAD_0BAD;
      i_slave_busy  = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         tests_run++;
         if (o_slave_ready !== 1'b1 || o_slave_out_valid !== 1'b0 ||
             o_slave_level !== '0 || o_slave_words !== '0) begin
            tests_failed++;
            $display("FAIL reset_during: got rdy=%b ov=%b lvl=%0d words=%0d expected 1/0/0/0",
                     o_slave_ready, o_slave_out_valid, o_slave_level, o_slave_words);
         end
      end
      rst           = 1'b0;
      i_slave_valid = 1'b0;
      tick();
      tests_run++;
      if (o_slave_ready !== 1'b1 || o_slave_out_valid !== 1'b0 ||
          o_slave_level !== '0 || o_slave_words !== '0) begin
         tests_failed++;
         $display("FAIL reset_after: got rdy=%b ov=%b lvl=%0d words=%0d expected 1/0/0/0",
                  o_slave_ready, o_slave_out_valid, o_slave_level, o_slave_words);
      end
   endtask

   task automatic test_single();
      i_slave_valid = 1'b1;
      i_slave_data  = 32'hDEAD_BEEF;
      i_slave_busy  = 1'b0;
      tick();
      i_slave_valid = 1'b0;
      tests_run++;
      if (o_slave_out_valid !== 1'b1 || o_slave_out_data !== 32'hDEAD_BEEF) begin
         tests_failed++;
         $display("FAIL single_out: got ov=%b data=%h expected 1/deadbeef",
                  o_slave_out_valid, o_slave_out_data);
      end
      tick();
      tests_run++;
      if (o_slave_out_valid !== 1'b0 || o_slave_words !== 16'd1) begin
         tests_failed++;
         $display("FAIL single_after: got ov=%b words=%0d expected 0/1",
                  o_slave_out_valid, o_slave_words);
      end
   endtask

   task automatic test_fill();
      int w0;
      w0           = exp_words;
      i_slave_busy = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         i_slave_valid = 1'b1;
         i_slave_data  = DATA_W'(i);
         tick();
      end
      i_slave_data = 32'h5;
      tests_run++;
      if (o_slave_level !== LVL_W'(4) || o_slave_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL fill_full: got lvl=%0d rdy=%b expected 4/0", o_slave_level, o_slave_ready);
      end
      tick();
      tick();
      tests_run++;
      if (o_slave_level !== LVL_W'(4) || 32'(o_slave_words) !== w0 + 4 ||
          o_slave_out_data !== 32'h1) begin
         tests_failed++;
         $display("FAIL fill_hold: got lvl=%0d words=%0d head=%h expected 4/%0d/1",
                  o_slave_level, o_slave_words, o_slave_out_data, w0 + 4);
      end
      i_slave_busy = 1'b0;
      tests_run++;
      if (o_slave_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL fill_ready_before_pop: got %b expected 0", o_slave_ready);
      end
      tick();
      tests_run++;
      if (o_slave_ready !== 1'b1 || o_slave_out_data !== 32'h2) begin
         tests_failed++;
         $display("FAIL fill_ready_after_pop: got rdy=%b head=%h expected 1/2",
                  o_slave_ready, o_slave_out_data);
      end
      tick();
      i_slave_valid = 1'b0;
      tests_run++;
      if (32'(o_slave_words) !== w0 + 5) begin
         tests_failed++;
         $display("FAIL fill_fifth: got words=%0d expected %0d", o_slave_words, w0 + 5);
      end
      drain();
   endtask

   task automatic test_streaming();
      do_reset();
      i_slave_busy  = 1'b0;
      i_slave_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         i_slave_data = DATA_W'(i);
         tick();
         tests_run++;
         if (o_slave_out_valid !== 1'b1 || o_slave_out_data !== DATA_W'(i) ||
             o_slave_level > LVL_W'(1)) begin
            tests_failed++;
            $display("FAIL stream_%0d: got ov=%b data=%h lvl=%0d expected 1/%h/<=1",
                     i, o_slave_out_valid, o_slave_out_data, o_slave_level, i);
         end
      end
      i_slave_valid = 1'b0;
      tick();
      tests_run++;
      if (o_slave_words !== 16'd20 || o_slave_out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL stream_end: got words=%0d ov=%b expected 20/0",
                  o_slave_words, o_slave_out_valid);
      end
   endtask

   task automatic test_random_stall();
      int          accepted = 0;
      int          cycles   = 0;
      logic [31:0] dval     = 32'h1000_0000;
      logic        v;
      while (accepted < 1000 && cycles < 20000) begin
         v             = 1'($urandom_range(0, 1));
         i_slave_valid = v;
         i_slave_busy  = 1'($urandom_range(0, 1));
         i_slave_data  = dval;
         // Ready is registered, so its value now is what the coming edge sees.
         if (v && o_slave_ready === 1'b1) begin
            accepted++;
            dval++;
         end
         tick();
         cycles++;
      end
      tests_run++;
      if (accepted != 1000) begin
         tests_failed++;
         $display("FAIL random_timeout: got %0d words expected 1000", accepted);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      i_slave_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         i_slave_valid = 1'b1;
         i_slave_data  = 32'h7700 + DATA_W'(i);
         tick();
      end
      i_slave_valid = 1'b0;
      tests_run++;
      if (o_slave_level !== LVL_W'(3)) begin
         tests_failed++;
         $display("FAIL mid_level3: got %0d expected 3", o_slave_level);
      end
      do_reset();
      tests_run++;
      if (o_slave_level !== '0 || o_slave_out_valid !== 1'b0 || o_slave_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL mid_after_rst: got lvl=%0d ov=%b rdy=%b expected 0/0/1",
                  o_slave_level, o_slave_out_valid, o_slave_ready);
      end
      i_slave_busy  = 1'b0;
      i_slave_valid = 1'b1;
      i_slave_data  = 32'hA5A5_A5A5;
      tick();
      i_slave_valid = 1'b0;
      tests_run++;
      if (o_slave_out_valid !== 1'b1 || o_slave_out_data !== 32'hA5A5_A5A5) begin
         tests_failed++;
         $display("FAIL mid_first_word: got ov=%b data=%h expected 1/a5a5a5a5",
                  o_slave_out_valid, o_slave_out_data);
      end
      drain();
   endtask

   initial begin
      rst           = 1'b1;
      i_slave_valid = 1'b0;
      i_slave_busy  = 1'b0;
      i_slave_data  = '0;
      test_reset();
      test_single();
      test_fill();
      test_streaming();
      test_random_stall();
      test_reset_mid();
      tick();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/slave_interface.md
# slave_interface

Receiving end of the valid/ready word link driven by the master interface. Accepts 32-bit words from the master side on a valid/ready handshake, buffers them in a small FIFO, and presents them to a downstream consumer that throttles with a busy signal. Sits between the link and the consumer logic. Back-pressures the master only when the buffer is full.

## Interface

Parameters:
- DATA_W, 32, width of link and output data
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- LVL_W, $clog2(DEPTH+1), width of the fill-level output
- CNT_W, 16, width of the accepted-word counter

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- i_slave_data  in  DATA_W  word from master
- i_slave_valid  in  1  master word valid
- o_slave_ready  out  1  slave can accept this cycle
- o_slave_out_data  out  DATA_W  head-of-FIFO word to consumer
- o_slave_out_valid  out  1  o_slave_out_data holds an unconsumed word
- i_slave_busy  in  1  consumer cannot take a word this cycle
- o_slave_level  out  LVL_W  current FIFO occupancy, 0..DEPTH
- o_slave_words  out  CNT_W  count of accepted words, wraps modulo 2^CNT_W

## Operation

- Storage: DEPTH × DATA_W register array, write pointer, read pointer (log2(DEPTH) bits, natural wrap), occupancy count (LVL_W bits).
- Push: push = i_slave_valid & o_slave_ready. Writes i_slave_data at wr_ptr; wr_ptr += 1.
- Pop: pop = o_slave_out_valid & ~i_slave_busy. rd_ptr += 1.
- Count: +1 on push only, −1 on pop only, unchanged on both or neither.
- o_slave_ready = (count != DEPTH). Derived only from registered state; no combinational path from i_slave_valid or i_slave_busy.
- o_slave_out_valid = (count != 0); o_slave_out_data = mem[rd_ptr] (first-word-fall-through). Value is don't-care when out_valid is low.
- o_slave_level = count. o_slave_words += 1 on every push, wraps to 0 after 2^CNT_W−1.
- Data is never dropped or duplicated; order is strictly preserved.
- Master-side rule honoured: a word is taken only on a cycle where valid and ready are both high. Valid without ready is legal and means wait.

## Timing

- Reset (rst high at a clk edge): count=0, wr_ptr=rd_ptr=0, o_slave_words=0. Hence o_slave_ready=1, o_slave_out_valid=0, o_slave_level=0. Memory contents are not reset.
- Reset mid-operation discards all buffered words. Reset has priority over push and pop on that edge.
- Latency: a word pushed at edge N is visible on o_slave_out_data with out_valid=1 in the cycle after edge N. There is no same-cycle bypass.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- Full (count=DEPTH): ready=0 and no push. A pop in that cycle makes ready=1 from the next cycle, so there is one bubble on the link.
- Empty (count=0): out_valid=0 and no pop regardless of busy. A simultaneous push makes count=1 next cycle.
- Simultaneous push and pop at 0<count<DEPTH: count unchanged; both pointers advance.
- busy held high: head word and out_data stay stable until the cycle busy drops.
- Pointer wrap: after DEPTH pushes wr_ptr returns to 0. This is correct through any number of wraps.

## Test plan

- Reset: assert rst 2 cycles with valid=1 → ready=1, out_valid=0, level=0, words=0 during and after reset; no word accepted while rst=1.
- Single word: push 0xDEADBEEF with busy=0 → next cycle out_valid=1, out_data=0xDEADBEEF, popped that cycle; following cycle out_valid=0, words=1.
- Fill: busy=1, push 0x1,0x2,0x3,0x4 back-to-back, keep valid=1 with 0x5 → level=4, ready=0, 0x5 held off. Drop busy → outputs 0x1..0x4 in order, ready returns 1 the cycle after first pop, then 0x5 accepted and output.
- Streaming: valid=1 and busy=0 for 20 cycles with data 0..19 → pointers wrap 5 times, output 0..19 in order at 1 cycle latency, level stays ≤1, words=20.
- Random stall: random valid and busy at 50% for 1000 words with incrementing data → scoreboard shows no loss, duplication or reorder; ready=0 exactly when level=4.
- Reset mid-stream: level=3, assert rst → next cycle level=0, out_valid=0, ready=1; subsequent push 0xA5A5A5A5 is the first word out.
